// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver: one shared segment bus, one-hot digit
// select, frame-coherent snapshot, freeze, leading-zero blanking and per-digit blink.
module seg7_scan_driver #(
    parameter int DIGITS       = 3,
    parameter int DIV          = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  freeze,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_tick
);

    localparam int IDX_W = $clog2((DIGITS > 1) ? DIGITS : 2);
    localparam int DIV_W = $clog2((DIV > 1) ? DIV : 2);
    localparam int BLK_W = $clog2((BLINK_FRAMES > 1) ? BLINK_FRAMES : 2);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_ph;
    logic                first_cyc;
    logic [4*DIGITS-1:0] snap_val;
    logic [DIGITS-1:0]   snap_dp;

    logic                div_last;
    logic                idx_last;
    logic                idx_wrap;
    logic                snap_load;
    logic [4*DIGITS-1:0] src_val;
    logic [DIGITS-1:0]   src_dp;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                lz_blank;
    logic                zero_run;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign div_last  = (div_cnt == DIV_LAST);
    assign idx_last  = (idx == IDX_LAST);
    assign idx_wrap  = div_last && idx_last;
    assign snap_load = (first_cyc || idx_wrap) && !freeze;

    // The first post-reset cycle decodes digit 0 from the value being captured right
    // now, so the very first displayed digit already belongs to the fresh snapshot.
    assign src_val = (first_cyc && !freeze) ? value : snap_val;
    assign src_dp  = (first_cyc && !freeze) ? dp_in : snap_dp;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        lz_blank  = 1'b0;
        zero_run  = 1'b1;
        sel_d     = '0;
        // Walk from the most significant nibble down so zero_run means "this and all above are 0".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (src_val[4*i +: 4] == 4'h0);
            sel_d[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                cur_nib   = src_val[4*i +: 4];
                cur_dp    = src_dp[i];
                cur_blink = blink_en[i];
                lz_blank  = blank_lz && (i > 0) && zero_run;
            end
        end
    end

    always_comb begin
        seg_d = {hex_to_seg(cur_nib), cur_dp};
        if (blink_ph && cur_blink) begin
            seg_d = 8'h00;
        end else if (lz_blank) begin
            seg_d = {7'b0000000, cur_dp};
        end
    end

    // Scan counters, blink phase and snapshot registers
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            first_cyc  <= 1'b1;
            snap_val   <= '0;
            snap_dp    <= '0;
            frame_tick <= 1'b0;
        end else begin
            first_cyc  <= 1'b0;
            frame_tick <= idx_wrap;
            div_cnt    <= div_last ? '0 : div_cnt + DIV_W'(1);
            if (div_last) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end
            if (frame_tick) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_ph  <= !blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
            if (snap_load) begin
                snap_val <= value;
                snap_dp  <= dp_in;
            end
        end
    end

    // Output register stage: pins show the digit addressed by idx one cycle earlier
    always_ff @(posedge clock) begin
        if (reset) begin
            seg       <= 8'h00;
            digit_sel <= '0;
        end else begin
            seg       <= seg_d;
            digit_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized traffic, checked each
// cycle against a model derived from the cycle count since reset release.
module tb_seg7_scan_driver;

    localparam int DIGITS = 3;
    localparam int DIV    = 4;
    localparam int BF     = 2;
    localparam int F      = DIGITS * DIV;

    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic              clock = 1'b0;
    logic              reset;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0] dp_in;
    logic              blank_lz;
    logic [DIGITS-1:0] blink_en;
    logic              freeze;
    logic [7:0]        seg;
    logic [DIGITS-1:0] digit_sel;
    logic              frame_tick;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    logic [4*DIGITS-1:0] msnap_val = '0;
    logic [DIGITS-1:0]   msnap_dp  = '0;
    logic [7:0]          exp_seg;
    logic [DIGITS-1:0]   exp_sel;
    logic                exp_tick;

    always #5 clock = ~clock;

    seg7_scan_driver #(
        .DIGITS(DIGITS),
        .DIV(DIV),
        .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .freeze(freeze),
        .seg(seg),
        .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp_v, n, $time);
        end
    endtask

    // Predict the outputs for the cycle after the coming edge, advance one clock, compare.
    task automatic step();
        int p;
        int di;
        int ph;
        logic [4*DIGITS-1:0] sv;
        logic [DIGITS-1:0]   sd;
        logic [3:0]          nib;
        if (reset) begin
            exp_seg   = 8'h00;
            exp_sel   = '0;
            exp_tick  = 1'b0;
            msnap_val = '0;
            msnap_dp  = '0;
            n         = 0;
        end else begin
            p  = n;
            di = (p / DIV) % DIGITS;
            ph = (p >= 1) ? (((p - 1) / F) / BF) % 2 : 0;
            if (p == 0 && !freeze) begin
                sv = value;
                sd = dp_in;
            end else begin
                sv = msnap_val;
                sd = msnap_dp;
            end
            nib = sv[4*di +: 4];
            if (ph == 1 && blink_en[di])
                exp_seg = 8'h00;
            else if (blank_lz && di > 0 && (sv >> (4*di)) == '0)
                exp_seg = {7'b0000000, sd[di]};
            else
                exp_seg = {HEX[nib], sd[di]};
            exp_sel  = DIGITS'(1 << di);
            exp_tick = (p % F == F - 1);
            if (!freeze && (p == 0 || p % F == F - 1)) begin
                msnap_val = value;
                msnap_dp  = dp_in;
            end
            n = p + 1;
        end
        @(posedge clock);
        #1;
        check_eq("seg", 32'(seg), 32'(exp_seg));
        check_eq("digit_sel", 32'(digit_sel), 32'(exp_sel));
        check_eq("frame_tick", 32'(frame_tick), 32'(exp_tick));
        if (n >= 1) check_eq("sel_onehot", 32'($countones(digit_sel)), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        value    = 12'h0A3;
        dp_in    = '0;
        blank_lz = 1'b0;
        blink_en = '0;
        freeze   = 1'b0;
        step();
        step();
        check_eq("rst_seg", 32'(seg), 32'h0);
        check_eq("rst_sel", 32'(digit_sel), 32'h0);

        // Basic scan of 0A3
        reset = 1'b0;
        step();
        check_eq("scan_d0_seg", 32'(seg), 32'hF2);
        check_eq("scan_d0_sel", 32'(digit_sel), 32'b001);
        repeat (4) step();
        check_eq("scan_d1_seg", 32'(seg), 32'hEE);
        check_eq("scan_d1_sel", 32'(digit_sel), 32'b010);
        repeat (4) step();
        check_eq("scan_d2_seg", 32'(seg), 32'hFC);
        check_eq("scan_d2_sel", 32'(digit_sel), 32'b100);
        repeat (3) step();
        check_eq("scan_tick", 32'(frame_tick), 32'h1);
        repeat (30) step();

        // Leading-zero blanking
        reset = 1'b1;
        step();
        value    = 12'h005;
        dp_in    = 3'b100;
        blank_lz = 1'b1;
        reset    = 1'b0;
        step();
        check_eq("lz_d0", 32'(seg), 32'hB6);
        repeat (4) step();
        check_eq("lz_d1", 32'(seg), 32'h00);
        repeat (4) step();
        check_eq("lz_d2", 32'(seg), 32'h01);
        repeat (20) step();

        // Snapshot coherence: change the value while digit 1 is being scanned
        blank_lz = 1'b0;
        dp_in    = '0;
        reset    = 1'b1;
        step();
        value = 12'h111;
        reset = 1'b0;
        repeat (F) step();
        while (n % F != 5) step();
        value = 12'h222;
        while (n % F != 9) step();
        check_eq("snap_old_d2", 32'(seg), 32'h60);
        while (n % F != 1) step();
        check_eq("snap_new_d0", 32'(seg), 32'hDA);
        repeat (2 * F) step();

        // Freeze holds the snapshot across frames
        freeze = 1'b1;
        value  = 12'($urandom);
        repeat (3 * F) step();
        freeze = 1'b0;
        repeat (2 * F) step();

        // Blink on digit 1
        reset = 1'b1;
        step();
        value    = 12'($urandom);
        blink_en = 3'b010;
        reset    = 1'b0;
        while (n != 30) step();
        check_eq("blink_off_d1", 32'(seg), 32'h00);
        while (n != 54) step();
        check_eq("blink_restored_d1", 32'(seg[7:1] != 7'd0), 32'h1);
        repeat (3 * F) step();

        // Reset in the middle of digit 2
        blink_en = '0;
        while (n % F != 9) step();
        reset = 1'b1;
        step();
        check_eq("midrst_seg", 32'(seg), 32'h0);
        check_eq("midrst_tick", 32'(frame_tick), 32'h0);
        value = 12'h3C7;
        reset = 1'b0;
        repeat (3 * F) step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0)  value    = 12'($urandom);
            if ($urandom_range(0, 9) == 0)  dp_in    = 3'($urandom);
            if ($urandom_range(0, 39) == 0) blink_en = 3'($urandom);
            if ($urandom_range(0, 49) == 0) freeze   = !freeze;
            if ($urandom_range(0, 99) == 0) blank_lz = !blank_lz;
            if ($urandom_range(0, 3) == 0)  value[11:4] = 8'h00;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed seven-segment driver for the board debug displays. It replaces the one-register-per-display combinational decode: one shared 8-bit segment bus plus a one-hot digit select scans DIGITS hex digits. It also adds frame-coherent snapshotting, freeze, leading-zero blanking and per-digit blink. It sits between debug taps (phase, control flags, register values) and the display pins.

Parameters:
DIGITS, 3, number of digits scanned (>=1); digit 0 is least significant.
DIV, 4, clock cycles each digit is driven per scan slot (>=1).
BLINK_FRAMES, 64, complete scan frames per blink half-period (>=1).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
value  in  4*DIGITS  hex nibble per digit; nibble i = value[4i+3:4i]
dp_in  in  DIGITS  decimal point per digit
blank_lz  in  1  enable leading-zero blanking
blink_en  in  DIGITS  per-digit blink enable
freeze  in  1  hold current snapshot
seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high
digit_sel  out  DIGITS  one-hot digit enable, active-high
frame_tick  out  1  one-cycle pulse at end of each complete frame

Behaviour:
- One clock; reset is synchronous and active-high, ports named clock and reset.
- Reset, sampled at a clock edge: div_cnt=0, idx=0, blink_cnt=0, blink_ph=0, snapshot value/dp=0, seg=8'h00, digit_sel=0, frame_tick=0. Reset mid-scan aborts the frame immediately; no partial-frame tick.
- Scan counter: div_cnt counts 0..DIV-1. At DIV-1 it wraps to 0 and idx advances. idx DIGITS-1 wraps to 0. DIV=1 advances idx every cycle.
- frame_tick is registered: high for exactly the one cycle after idx wraps DIGITS-1->0. DIGITS=1 gives one pulse every DIV cycles.
- Snapshot: value and dp_in are copied into shadow registers when freeze=0 at these two points only:
  - the first cycle after reset deasserts;
  - every idx wrap to 0.
  With freeze=1 the shadow holds. No mid-frame update ever occurs.
- Output latency: seg and digit_sel are registered and reflect the idx of the previous cycle. The first cycle after reset release shows digit_sel=0 and seg=0. The next cycle shows digit_sel=1<<0 with digit 0 content.
- digit_sel is always one-hot after the first post-reset cycle and is never all-zero during scanning.
- Hex decode {a..g}, nibble 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111. seg[0]=shadow dp.
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked when shadow nibble i and all higher nibbles are 0. Blanked means seg[7:1]=0; dp still shown. Digit 0 is never blanked.
- Blink: blink_cnt increments on each frame_tick. At BLINK_FRAMES-1 it wraps and toggles blink_ph. When blink_ph=1 and blink_en[idx]=1, seg=8'h00 including dp; digit_sel is still asserted. blink_en is sampled live, not snapshotted.
- Precedence: blink blanking > leading-zero blanking > decode.
- Widths: idx is clog2(max(DIGITS,2)) bits. No arithmetic overflow: all counters wrap explicitly at their terminal value.

Test Plan:
- Reset/scan (DIGITS=3, DIV=4), value=12'h0A3, dp_in=0 -> after release, digit_sel cycles 001,010,100 for 4 cycles each; seg = 11110010, 11101110, 11111100. frame_tick is pulsed every 12 cycles.
- Leading-zero blanking, blank_lz=1, value=12'h005, dp_in=3'b100 -> digit 0 seg=10110110; digit 1 seg=0; digit 2 seg=00000001.
- Snapshot coherence: change value 12'h111->12'h222 mid-frame (idx=1) -> remainder of frame shows 1s. Next frame shows 2s on all digits, starting with digit 0.
- freeze=1, then change value -> display unchanged across 3 frames. Release freeze -> new value shown from the next frame start.
- Blink (BLINK_FRAMES=2), blink_en=3'b010 -> digit 1 seg=0 during frames 2-3, restored in frames 4-5. Digits 0 and 2 are unaffected. digit_sel remains one-hot throughout.
- Reset asserted at idx=2, div_cnt=1 -> next cycle all outputs 0, no frame_tick. Scan restarts at digit 0 with a fresh snapshot.
